mux_scan_arbiter: RTL and testbench

- Round-robin arbiter that shares the 7:1 channel mux and counter datapath (channels a..g, 3-bit select) between seven requesters.
- Drives the mux select `addr` and a one-hot grant. Each grant is bounded by a hold timeout.
- Inserts one dead cycle between grants so the mux output settles before the next owner samples `mux_out`.
- Sits directly in front of the mux/counter block and replaces the bench-driven `addr` sequencing.

---
 rtl/mux_pkg.sv | 21 ++
 rtl/mux_scan_arbiter_rr_pick.sv | 33 +++
 rtl/mux_scan_arbiter.sv | 123 ++++++++++++
 tb/tb_mux_scan_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the mux/counter front-end arbiter.
package mux_pkg;

  localparam int unsigned ADDR_W         = 3;
  localparam int unsigned MAX_CH         = 1 << ADDR_W;
  localparam int unsigned DEFAULT_NUM_CH = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // Next channel index after idx, wrapping at n.
  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] idx,
                                                 input int unsigned        n);
    if (32'(idx) >= n - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/mux_scan_arbiter_rr_pick.sv
// Round-robin candidate search: first set request at or after ptr, wrapping.
module rr_pick
  import mux_pkg::*;
#(
  parameter int unsigned NUM_CH = DEFAULT_NUM_CH
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ADDR_W-1:0] ptr,
  output logic              any,
  output logic [ADDR_W-1:0] idx
);

  logic [MAX_CH-1:0] req_pad;
  int unsigned       cand;

  // Walk channels starting from ptr; the first hit wins.
  always_comb begin
    any     = 1'b0;
    idx     = '0;
    cand    = 0;
    req_pad = '0;
    req_pad[NUM_CH-1:0] = req;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (!any && req_pad[cand[ADDR_W-1:0]]) begin
        any = 1'b1;
        idx = cand[ADDR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_scan_arbiter.sv
// Round-robin owner of the shared 7:1 mux: grants one requester at a time,
// bounds each grant by MAX_HOLD cycles and inserts one dead cycle between owners.
module mux_scan_arbiter
  import mux_pkg::*;
#(
  parameter  int unsigned NUM_CH   = DEFAULT_NUM_CH,
  parameter  int unsigned MAX_HOLD = 8,
  localparam int unsigned HW       = $clog2(MAX_HOLD + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              timeout
);

  arb_state_e        state_q, state_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [HW-1:0]     hold_q, hold_d;

  logic              pick_any;
  logic [ADDR_W-1:0] pick_idx;
  logic [MAX_CH-1:0] pick_onehot;
  logic [MAX_CH-1:0] req_pad;
  logic              owner_req;

  rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign pick_onehot = MAX_CH'(1) << pick_idx;

  // Owner's request bit, with unused high channels padded to zero.
  always_comb begin
    req_pad = '0;
    req_pad[NUM_CH-1:0] = req;
    owner_req = req_pad[addr_q];
  end

  // Next-state, grant and hold-counter logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    case (state_q)
      IDLE, GAP: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (en && pick_any) begin
          state_d = GRANT;
          gnt_d   = pick_onehot[NUM_CH-1:0];
          addr_d  = pick_idx;
          busy_d  = 1'b1;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        hold_d = hold_q + 1'b1;
        // Release has priority over timeout when both happen together.
        if (!owner_req) begin
          state_d = GAP;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = wrap_inc(addr_q, NUM_CH);
        end else if (hold_q == HW'(MAX_HOLD - 1)) begin
          state_d   = GAP;
          gnt_d     = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          ptr_d     = wrap_inc(addr_q, NUM_CH);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
    end
  end

  assign gnt     = gnt_q;
  assign addr    = addr_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux_scan_arbiter.sv
// Scoreboard bench: two arbiters (MAX_HOLD 8 and 2) share stimulus; a
// transaction-level model predicts each cycle's outputs into a queue.
module tb_mux_scan_arbiter;

  typedef struct packed {
    logic [6:0] gnt;
    logic [2:0] addr;
    logic       busy;
    logic       to;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [6:0] req;
  logic [6:0] gnt_a, gnt_b;
  logic [2:0] addr_a, addr_b;
  logic       busy_a, busy_b, to_a, to_b;

  int total = 0;
  int bad   = 0;
  exp_t q[$];

  // Model state per instance: current owner (-1 = none), grant cycles so far,
  // round-robin start, last owner, and timeout seen at the latest edge.
  int owner[2];
  int held[2];
  int ptr[2];
  int maddr[2];
  bit mto[2];
  int mh[2] = '{8, 2};

  always #5 clk = ~clk;

  mux_scan_arbiter #(.NUM_CH(7), .MAX_HOLD(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt_a), .addr(addr_a), .busy(busy_a), .timeout(to_a)
  );

  mux_scan_arbiter #(.NUM_CH(7), .MAX_HOLD(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt_b), .addr(addr_b), .busy(busy_b), .timeout(to_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1; held[k] = 0; ptr[k] = 0; maddr[k] = 0; mto[k] = 1'b0;
    end
  endtask

  // One clock edge as seen by instance k with request vector r and enable e.
  task automatic model_edge(input int k, input logic [6:0] r, input logic e);
    int c;
    mto[k] = 1'b0;
    if (owner[k] >= 0) begin
      if (!r[owner[k][2:0]]) begin
        ptr[k]   = (owner[k] + 1) % 7;
        owner[k] = -1;
      end else if (held[k] == mh[k]) begin
        ptr[k]   = (owner[k] + 1) % 7;
        owner[k] = -1;
        mto[k]   = 1'b1;
      end else begin
        held[k]++;
      end
    end else if (e && r != 7'd0) begin
      for (int i = 0; i < 7; i++) begin
        c = (ptr[k] + i) % 7;
        if (r[c[2:0]]) begin
          owner[k] = c; held[k] = 1; maddr[k] = c;
          break;
        end
      end
    end
  endtask

  function automatic obs_t model_obs(input int k);
    obs_t o;
    o.gnt  = (owner[k] >= 0) ? 7'(1 << owner[k]) : 7'd0;
    o.addr = maddr[k][2:0];
    o.busy = (owner[k] >= 0);
    o.to   = mto[k];
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    model_edge(0, req, en);
    model_edge(1, req, en);
    q.push_back({model_obs(0), model_obs(1)});
  endtask

  // Reset pulse placed between edges: outputs must clear without a clock.
  task automatic reset_mid();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_gnt_a", int'(gnt_a), 0);
    chk("async_busy_a", int'(busy_a), 0);
    chk("async_to_a", int'(to_a), 0);
    chk("async_gnt_b", int'(gnt_b), 0);
    chk("async_busy_b", int'(busy_b), 0);
    model_reset();
    q.push_back({model_obs(0), model_obs(1)});
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compare every cycle's outputs against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt_a",  int'(gnt_a),  int'(e.a.gnt));
        chk("addr_a", int'(addr_a), int'(e.a.addr));
        chk("busy_a", int'(busy_a), int'(e.a.busy));
        chk("to_a",   int'(to_a),   int'(e.a.to));
        chk("gnt_b",  int'(gnt_b),  int'(e.b.gnt));
        chk("addr_b", int'(addr_b), int'(e.b.addr));
        chk("busy_b", int'(busy_b), int'(e.b.busy));
        chk("to_b",   int'(to_b),   int'(e.b.to));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 7'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt_a", int'(gnt_a), 0);
    chk("rst_addr_a", int'(addr_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_to_a", int'(to_a), 0);
    rst_n = 1'b1;

    // Idle with no requests.
    repeat (10) step();

    // Single request on channel 2, then release.
    req = 7'b0000100;
    repeat (4) step();
    req = 7'd0;
    repeat (4) step();

    // Everyone requesting: rotation and timeouts.
    req = 7'h7f;
    repeat (40) step();

    // Asynchronous reset while a grant is active; rotation restarts at 0.
    reset_mid();
    repeat (12) step();

    // Lone requester held past MAX_HOLD.
    req = 7'b0100000;
    repeat (25) step();
    req = 7'd0;
    repeat (3) step();

    // Enable dropped mid-grant of channel 3.
    req = 7'b0011000;
    step();
    step();
    en = 1'b0;
    repeat (14) step();
    en = 1'b1;
    repeat (8) step();

    // Randomized sticky requests, enable glitches and occasional resets.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) reset_mid();
      else step();
      for (int b = 0; b < 7; b++)
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      if ($urandom_range(0, 15) == 0) en = ~en;
    end
    en  = 1'b1;
    req = 7'd0;
    repeat (4) step();

    @(negedge clk);
    #1;
    chk("queue_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
